interrupt_sequencer: RTL and testbench
======================================

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single processor clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port interrupt, input, 1 bit: external interrupt request, sampled every cycle.
REQ-004 The block SHALL have port branch_in_flight, input, 1 bit: a taken branch/flush is pending in EX; acceptance is deferred while this is 1.
REQ-005 The block SHALL have port pc, input, 32 bits: address of the next instruction to resume.
REQ-006 The block SHALL have port flags, input, 4 bits: current CCR.
REQ-007 The block SHALL have port rti, input, 1 bit: return-from-interrupt decoded in ID.
REQ-008 The block SHALL have port vec_data, input, 16 bits: data-memory read data, valid in the same cycle as vec_rd (combinational read).
REQ-009 The block SHALL have port stall_fetch, output, 1 bit: freezes PC and IF/ID.
REQ-010 The block SHALL have port inject_bubble, output, 1 bit: forces the ID/EX control bits to zero.
REQ-011 The block SHALL have ports push_en (output, 1 bit) and push_data (output, 16 bits): SP-decrement stack write.
REQ-012 The block SHALL have ports vec_rd (output, 1 bit) and vec_addr (output, 16 bits): vector-table read.
REQ-013 The block SHALL have ports pc_load (output, 1 bit) and pc_value (output, 32 bits): PC overwrite.
REQ-014 The block SHALL have ports flags_restore (output, 1 bit) and saved_flags (output, 4 bits): CCR restore on rti.
REQ-015 The block SHALL have port busy, output, 1 bit: 1 in any state other than IDLE.

Function
REQ-016 pending SHALL be set in any cycle with interrupt=1 and cleared only in the acceptance cycle; requests while pending=1 SHALL merge into one.
REQ-017 States SHALL be IDLE, DRAIN, PUSH_HI, PUSH_LO, VEC_HI, VEC_LO, LOAD.
REQ-018 IDLE->DRAIN SHALL occur when (pending or interrupt)=1 and branch_in_flight=0 (acceptance); in that cycle saved_flags<=flags and the drain counter is loaded with 2.
REQ-019 In DRAIN, stall_fetch=1 and inject_bubble=1; the counter decrements each cycle; when counter=0 the state SHALL go to PUSH_HI; DRAIN therefore lasts 3 cycles.
REQ-020 PUSH_HI SHALL drive push_en=1 and push_data=pc_latched[31:16]; PUSH_LO SHALL drive push_en=1 and push_data=pc_latched[15:0]; pc_latched is captured at acceptance.
REQ-021 VEC_HI SHALL drive vec_rd=1 and vec_addr=16'h0000, and capture vec_data into vec_hi; VEC_LO SHALL drive vec_rd=1 and vec_addr=16'h0001, and capture vec_data into vec_lo.
REQ-022 LOAD SHALL drive pc_load=1 and pc_value={vec_hi,vec_lo} for exactly 1 cycle, then return to IDLE.
REQ-023 stall_fetch and inject_bubble SHALL be 1 in every non-IDLE state; push_en, vec_rd and pc_load SHALL be 0 outside their own states.
REQ-024 Latency from the acceptance edge to pc_load=1 SHALL be 8 cycles: 3 DRAIN, 2 PUSH, 2 VEC, then LOAD.
REQ-025 flags_restore SHALL equal rti AND (state==IDLE), combinationally; saved_flags SHALL be held until the next acceptance.
REQ-026 rti in a non-IDLE state SHALL be ignored; interrupt with branch_in_flight=1 SHALL stay pending until branch_in_flight=0.
REQ-027 An interrupt arriving during a sequence SHALL be accepted on the first IDLE cycle after LOAD, i.e. back-to-back with no lost request.
REQ-028 Simultaneous rti and acceptance in IDLE: flags_restore=1 SHALL use the old saved_flags; the new capture takes effect from the next cycle.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, clear pending, counter, pc_latched, vec_hi/lo and saved_flags to 0, and make all outputs 0, including mid-sequence; reset SHALL dominate interrupt in the same cycle.

Verification
REQ-030 Bench: interrupt 1-cycle pulse, pc=32'h0000_0120, flags=4'b1010, vec words 16'h0000/16'h0200 -> DRAIN 3 cycles, then push 16'h0000 and 16'h0120, pc_load with 32'h0000_0200 at acceptance+8, saved_flags=4'b1010.
REQ-031 Bench: interrupt while branch_in_flight=1 for 2 cycles -> busy stays 0; accepted on the first cycle branch_in_flight=0.
REQ-032 Bench: second interrupt pulse during PUSH_LO -> after LOAD, one IDLE cycle, then a new DRAIN; exactly 2 sequences total.
REQ-033 Bench: reset asserted during VEC_HI -> next cycle IDLE, all outputs 0, no pc_load.
REQ-034 Bench: rti in IDLE after a sequence -> flags_restore=1 in the same cycle with saved_flags=4'b1010; rti during DRAIN -> flags_restore=0.

Source files
------------

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: drains the pipe, pushes the resume PC and fetches
// the handler vector. The return-from-interrupt path restores the saved CCR.
module interrupt_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        interrupt,
   input  logic        branch_in_flight,
   input  logic [31:0] pc,
   input  logic [3:0]  flags,
   input  logic        rti,
   input  logic [15:0] vec_data,
   output logic        stall_fetch,
   output logic        inject_bubble,
   output logic        push_en,
   output logic [15:0] push_data,
   output logic        vec_rd,
   output logic [15:0] vec_addr,
   output logic        pc_load,
   output logic [31:0] pc_value,
   output logic        flags_restore,
   output logic [3:0]  saved_flags,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_PUSH_HI = 3'd2,
      ST_PUSH_LO = 3'd3,
      ST_VEC_HI  = 3'd4,
      ST_VEC_LO  = 3'd5,
      ST_LOAD    = 3'd6
   } state_t;

   state_t      r_state;
   logic        r_pending;
   logic [1:0]  r_drain_cnt;
   logic [31:0] r_pc_latched;
   logic [15:0] r_vec_hi;
   logic [15:0] r_vec_lo;
   logic [3:0]  r_saved_flags;
   logic        r_stall;
   logic        r_bubble;
   logic        r_push_en;
   logic [15:0] r_push_data;
   logic        r_vec_rd;
   logic [15:0] r_vec_addr;
   logic        r_pc_load;
   logic        r_busy;

   logic        w_is_idle;
   logic        w_accept;

   assign w_is_idle = (r_state == ST_IDLE);
   // A request arriving in the same cycle as acceptance is folded in directly.
   assign w_accept  = w_is_idle & (r_pending | interrupt) & ~branch_in_flight;

   // Sequencer state, request latch, captured context and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pending     <= 1'b0;
         r_drain_cnt   <= 2'd0;
         r_pc_latched  <= 32'h0000_0000;
         r_vec_hi      <= 16'h0000;
         r_vec_lo      <= 16'h0000;
         r_saved_flags <= 4'h0;
         r_stall       <= 1'b0;
         r_bubble      <= 1'b0;
         r_push_en     <= 1'b0;
         r_push_data   <= 16'h0000;
         r_vec_rd      <= 1'b0;
         r_vec_addr    <= 16'h0000;
         r_pc_load     <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_pending   <= w_accept ? 1'b0 : (r_pending | interrupt);
         r_stall     <= 1'b1;
         r_bubble    <= 1'b1;
         r_busy      <= 1'b1;
         r_push_en   <= 1'b0;
         r_push_data <= 16'h0000;
         r_vec_rd    <= 1'b0;
         r_vec_addr  <= 16'h0000;
         r_pc_load   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state       <= ST_DRAIN;
                  r_drain_cnt   <= 2'd2;
                  r_saved_flags <= flags;
                  r_pc_latched  <= pc;
               end else begin
                  r_state  <= ST_IDLE;
                  r_stall  <= 1'b0;
                  r_bubble <= 1'b0;
                  r_busy   <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == 2'd0) begin
                  r_state     <= ST_PUSH_HI;
                  r_push_en   <= 1'b1;
                  r_push_data <= r_pc_latched[31:16];
               end else begin
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= r_drain_cnt - 2'd1;
               end
            end
            ST_PUSH_HI: begin
               r_state     <= ST_PUSH_LO;
               r_push_en   <= 1'b1;
               r_push_data <= r_pc_latched[15:0];
            end
            ST_PUSH_LO: begin
               r_state    <= ST_VEC_HI;
               r_vec_rd   <= 1'b1;
               r_vec_addr <= 16'h0000;
            end
            ST_VEC_HI: begin
               r_state    <= ST_VEC_LO;
               r_vec_hi   <= vec_data;
               r_vec_rd   <= 1'b1;
               r_vec_addr <= 16'h0001;
            end
            ST_VEC_LO: begin
               r_state   <= ST_LOAD;
               r_vec_lo  <= vec_data;
               r_pc_load <= 1'b1;
            end
            ST_LOAD: begin
               // Always pass through IDLE so a merged request is taken next cycle.
               r_state  <= ST_IDLE;
               r_stall  <= 1'b0;
               r_bubble <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_stall  <= 1'b0;
               r_bubble <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign stall_fetch   = r_stall;
   assign inject_bubble = r_bubble;
   assign push_en       = r_push_en;
   assign push_data     = r_push_data;
   assign vec_rd        = r_vec_rd;
   assign vec_addr      = r_vec_addr;
   assign pc_load       = r_pc_load;
   assign pc_value      = {r_vec_hi, r_vec_lo};
   // Uses the pre-capture value when rti coincides with a new acceptance.
   assign flags_restore = rti & w_is_idle;
   assign saved_flags   = r_saved_flags;
   assign busy          = r_busy;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: directed scenarios queue the expected
// push/vector/load/restore events; a negedge monitor pops and compares them.
module tb_interrupt_sequencer;

   logic        clk;
   logic        reset;
   logic        interrupt;
   logic        branch_in_flight;
   logic [31:0] pc;
   logic [3:0]  flags;
   logic        rti;
   logic [15:0] vec_data;
   logic        stall_fetch;
   logic        inject_bubble;
   logic        push_en;
   logic [15:0] push_data;
   logic        vec_rd;
   logic [15:0] vec_addr;
   logic        pc_load;
   logic [31:0] pc_value;
   logic        flags_restore;
   logic [3:0]  saved_flags;
   logic        busy;

   logic [15:0] vmem0;
   logic [15:0] vmem1;
   int          cyc;
   int          n_vec;
   int          n_miss;

   typedef struct {
      int          kind;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   ev_t sb[$];

   localparam int K_PUSH = 0;
   localparam int K_VEC  = 1;
   localparam int K_LOAD = 2;
   localparam int K_REST = 3;

   interrupt_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .interrupt        (interrupt),
      .branch_in_flight (branch_in_flight),
      .pc               (pc),
      .flags            (flags),
      .rti              (rti),
      .vec_data         (vec_data),
      .stall_fetch      (stall_fetch),
      .inject_bubble    (inject_bubble),
      .push_en          (push_en),
      .push_data        (push_data),
      .vec_rd           (vec_rd),
      .vec_addr         (vec_addr),
      .pc_load          (pc_load),
      .pc_value         (pc_value),
      .flags_restore    (flags_restore),
      .saved_flags      (saved_flags),
      .busy             (busy)
   );

   assign vec_data = (vec_rd && vec_addr == 16'h0000) ? vmem0 :
                     (vec_rd && vec_addr == 16'h0001) ? vmem1 : 16'h0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [31:0] data, input int at);
      ev_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = at;
      sb.push_back(e);
   endtask

   // Full sequence accepted in cycle k: pushes at k+4/k+5, vector reads at k+6/k+7, load at k+8.
   task automatic exp_seq(input int k, input logic [31:0] pcv, input logic [15:0] v0,
                          input logic [15:0] v1);
      push_ev(K_PUSH, {16'h0000, pcv[31:16]}, k + 4);
      push_ev(K_PUSH, {16'h0000, pcv[15:0]},  k + 5);
      push_ev(K_VEC,  32'h0000_0000,          k + 6);
      push_ev(K_VEC,  32'h0000_0001,          k + 7);
      push_ev(K_LOAD, {v0, v1},               k + 8);
   endtask

   task automatic take(input int kind, input logic [31:0] data);
      ev_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL unexpected event kind %0d data %h @cycle %0d, expected none", kind, data, cyc);
      end else begin
         e = sb.pop_front();
         chk("event kind", kind, e.kind);
         chk("event data", data, e.data);
         chk("event cycle", cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (push_en)       take(K_PUSH, {16'h0000, push_data});
      if (vec_rd)        take(K_VEC,  {16'h0000, vec_addr});
      if (pc_load)       take(K_LOAD, pc_value);
      if (flags_restore) take(K_REST, {28'h0, saved_flags});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " stall_fetch"},   {31'h0, stall_fetch},   32'h0);
      chk({tag, " inject_bubble"}, {31'h0, inject_bubble}, 32'h0);
      chk({tag, " push_en"},       {31'h0, push_en},       32'h0);
      chk({tag, " vec_rd"},        {31'h0, vec_rd},        32'h0);
      chk({tag, " pc_load"},       {31'h0, pc_load},       32'h0);
      chk({tag, " pc_value"},      pc_value,               32'h0);
      chk({tag, " saved_flags"},   {28'h0, saved_flags},   32'h0);
      chk({tag, " busy"},          {31'h0, busy},          32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      n_vec = 0;
      n_miss = 0;
      reset = 1'b1;
      interrupt = 1'b0;
      branch_in_flight = 1'b0;
      pc = 32'h0;
      flags = 4'h0;
      rti = 1'b0;
      vmem0 = 16'h0000;
      vmem1 = 16'h0200;
      ticks(2);
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      // Basic sequence with context capture at acceptance, then rti in IDLE.
      k = cyc;
      interrupt = 1'b1;
      pc = 32'h0000_0120;
      flags = 4'b1010;
      exp_seq(k, 32'h0000_0120, 16'h0000, 16'h0200);
      push_ev(K_REST, 32'h0000_000A, k + 9);
      tick();
      interrupt = 1'b0;
      pc = 32'hDEAD_BEEF;
      flags = 4'b0101;
      chk("drain busy", {31'h0, busy}, 32'h1);
      chk("drain stall_fetch", {31'h0, stall_fetch}, 32'h1);
      chk("drain inject_bubble", {31'h0, inject_bubble}, 32'h1);
      ticks(2);
      chk("drain end stall_fetch", {31'h0, stall_fetch}, 32'h1);
      ticks(6);
      chk("idle after load busy", {31'h0, busy}, 32'h0);
      chk("saved_flags seq1", {28'h0, saved_flags}, 32'h0000_000A);
      rti = 1'b1;
      tick();
      rti = 1'b0;
      tick();

      // Acceptance deferred by branch_in_flight; rti during DRAIN ignored.
      k = cyc;
      branch_in_flight = 1'b1;
      interrupt = 1'b1;
      pc = 32'h0000_4444;
      flags = 4'b0110;
      vmem0 = 16'h1234;
      vmem1 = 16'h5678;
      tick();
      interrupt = 1'b0;
      chk("deferred busy 1", {31'h0, busy}, 32'h0);
      tick();
      branch_in_flight = 1'b0;
      chk("deferred busy 2", {31'h0, busy}, 32'h0);
      exp_seq(k + 2, 32'h0000_4444, 16'h1234, 16'h5678);
      tick();
      chk("accepted busy", {31'h0, busy}, 32'h1);
      rti = 1'b1;
      #1;
      chk("rti in drain flags_restore", {31'h0, flags_restore}, 32'h0);
      tick();
      rti = 1'b0;
      ticks(7);
      chk("saved_flags seq2", {28'h0, saved_flags}, 32'h0000_0006);
      tick();

      // Request during PUSH_LO is taken after one IDLE cycle: two sequences total.
      k = cyc;
      interrupt = 1'b1;
      pc = 32'h0001_0120;
      flags = 4'b0011;
      vmem0 = 16'h0000;
      vmem1 = 16'h0300;
      exp_seq(k, 32'h0001_0120, 16'h0000, 16'h0300);
      exp_seq(k + 9, 32'hABCD_0004, 16'h0001, 16'h0400);
      tick();
      interrupt = 1'b0;
      pc = 32'hABCD_0004;
      ticks(4);
      interrupt = 1'b1;
      tick();
      interrupt = 1'b0;
      ticks(2);
      vmem0 = 16'h0001;
      vmem1 = 16'h0400;
      tick();
      chk("b2b idle gap busy", {31'h0, busy}, 32'h0);
      tick();
      chk("b2b second drain busy", {31'h0, busy}, 32'h1);
      ticks(8);
      chk("b2b done busy", {31'h0, busy}, 32'h0);
      ticks(3);
      chk("b2b no third busy", {31'h0, busy}, 32'h0);

      // Reset during VEC_HI, together with a new interrupt.
      k = cyc;
      interrupt = 1'b1;
      pc = 32'h0000_0777;
      flags = 4'b1111;
      push_ev(K_PUSH, 32'h0000_0000, k + 4);
      push_ev(K_PUSH, 32'h0000_0777, k + 5);
      push_ev(K_VEC,  32'h0000_0000, k + 6);
      tick();
      interrupt = 1'b0;
      ticks(5);
      reset = 1'b1;
      interrupt = 1'b1;
      tick();
      chk_all_zero("mid-seq reset");
      reset = 1'b0;
      interrupt = 1'b0;
      ticks(10);
      chk("post reset busy", {31'h0, busy}, 32'h0);
      chk("scoreboard drained", sb.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
